lms_ctr_ram_arbiter: RTL

- Two-master front end for the 1024x32 single-port on-chip RAM in the lms_ctr subsystem.
- The requesters are the CPU data master (m0) and the SPI/config DMA master (m1).
- After reset it clears the whole RAM to zero, then arbitrates one Avalon-MM transfer per cycle (round-robin, optional lock for read-modify-write).
- It routes the 1-cycle-latency read data back to the master that issued the read.

---
 rtl/lms_ctr_ram_arb_pkg.sv | 24 ++
 rtl/lms_ctr_ram_arbiter_if.sv | 26 ++
 rtl/lms_ctr_rr_arb2.sv | 75 +++++++
 rtl/lms_ctr_ram_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/lms_ctr_ram_arb_pkg.sv
// Shared types and helpers for the lms_ctr two-master RAM front end.
// Holds the sequencer states, the master-id type and the RAM depth derivation.
package lms_ctr_ram_arb_pkg;

  typedef enum logic {
    CLR = 1'b0,
    ARB = 1'b1
  } state_t;

  // Identifies one of the two requesters: 0 = CPU data master, 1 = SPI/config DMA.
  typedef logic mid_t;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [1:0] mid_onehot(input mid_t m);
    return m ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lms_ctr_ram_arbiter_if.sv
// One Avalon-MM master port into the RAM arbiter.
// The requester side uses the master modport, the arbiter the slave modport.
interface lms_ctr_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                lock;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/lms_ctr_rr_arb2.sv
// Two-way round-robin grant with a lock override and a lock watchdog.
// The grant is combinational; last winner, lock owner and watchdog are registered.
module lms_ctr_rr_arb2
  import lms_ctr_ram_arb_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] lock_req,
  output logic [1:0] grant,
  output mid_t       winner,
  output logic       lock_err
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  mid_t             last_grant;
  logic             lock_vld;
  mid_t             lock_own;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_inc;

  assign lock_cnt_inc = lock_cnt + 1'b1;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    winner = last_grant;
    grant  = 2'b00;
    if (en) begin
      if (lock_vld) begin
        winner = lock_own;
        grant  = req & mid_onehot(lock_own);
      end else begin
        case (req)
          2'b01:   winner = 1'b0;
          2'b10:   winner = 1'b1;
          2'b11:   winner = ~last_grant;
          default: winner = last_grant;
        endcase
        grant = (req == 2'b00) ? 2'b00 : mid_onehot(winner);
      end
    end
  end

  // NOTE: registers use <= so every update samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      lock_vld   <= 1'b0;
      lock_own   <= 1'b0;
      lock_cnt   <= '0;
      lock_err   <= 1'b0;
    end else if (grant != 2'b00) begin
      // While locked only the owner can be granted, so this also covers unlock.
      last_grant <= winner;
      lock_cnt   <= '0;
      lock_vld   <= lock_req[winner];
      if (lock_req[winner]) begin
        lock_own <= winner;
      end
    end else if (en && lock_vld && !req[lock_own]) begin
      if (lock_cnt_inc == CNT_W'(LOCK_TIMEOUT)) begin
        lock_vld <= 1'b0;
        lock_err <= 1'b1;
        lock_cnt <= '0;
      end else begin
        lock_cnt <= lock_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/lms_ctr_ram_arbiter.sv
// Two-master front end for the lms_ctr single-port RAM: zero-fill after reset,
// then one arbitrated transfer per cycle with read data routed to its issuer.
module lms_ctr_ram_arbiter
  import lms_ctr_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned LOCK_TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset,
  lms_ctr_ram_arbiter_if.slave m0,
  lms_ctr_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                init_done,
  output logic                lock_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = depth_of(ADDR_W);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rd_vld;
  mid_t              rd_own;
  logic [1:0]        req;
  logic [1:0]        grant;
  mid_t              winner;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  lms_ctr_rr_arb2 #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (state == ARB),
    .req      (req),
    .lock_req ({m1.lock, m0.lock}),
    .grant    (grant),
    .winner   (winner),
    .lock_err (lock_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? CLR : ARB;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    case (state)
      CLR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = clr_cnt;
        mem_byteenable = '1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = ARB;
        end
      end
      ARB: begin
        if (grant != 2'b00) begin
          mem_chipselect = 1'b1;
          mem_write      = winner ? m1.write      : m0.write;
          mem_address    = winner ? m1.address    : m0.address;
          mem_byteenable = winner ? m1.byteenable : m0.byteenable;
          mem_writedata  = winner ? m1.writedata  : m0.writedata;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt   <= '0;
      init_done <= 1'b0;
      rd_vld    <= 1'b0;
      rd_own    <= 1'b0;
    end else begin
      if (state == CLR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      init_done <= (state_next == ARB);
      // A request carrying both read and write was issued as a write: no return.
      rd_vld    <= (grant != 2'b00) && !mem_write;
      if (grant != 2'b00) begin
        rd_own <= winner;
      end
    end
  end

  assign mem_clken = 1'b1;

  assign m0.waitrequest   = req[0] & ~grant[0];
  assign m1.waitrequest   = req[1] & ~grant[1];
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_vld & (rd_own == 1'b0);
  assign m1.readdatavalid = rd_vld & (rd_own == 1'b1);

  logic unused_be_w;
  assign unused_be_w = (BE_W == 0);

endmodule
